// File: rtl/btn_pkg.sv
// Shared types and helpers for the button debounce controller.
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        RELEASE_PEND
    } btn_state_t;

    // Never returns 0, so a degenerate parameter still yields a legal 1-bit vector.
    function automatic int clog2_safe(input int value);
        int w;
        w = (value <= 1) ? 1 : $clog2(value);
        return w;
    endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One debounce channel: press/release qualification against the shared tick,
// plus a saturating hold counter for long-press detection.
//
// state        | meaning
// -------------+---------------------------------------------------------
// RELEASED     | accepted level is released, waiting for activity
// PRESS_PEND   | pin reads pressed, counting stable ticks before accepting
// PRESSED      | accepted level is pressed, hold counter running
// RELEASE_PEND | pin reads released, counting stable ticks before accepting
module btn_debounce_chan
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_MS   = 10,
    parameter int LONG_PRESS_MS = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic act_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int              HW        = clog2_safe(LONG_PRESS_MS + 1);
    localparam logic [7:0]      DCNT_LAST = 8'(DEBOUNCE_MS - 1);
    localparam logic [HW-1:0]   HCNT_MAX  = HW'(LONG_PRESS_MS);
    localparam logic [HW-1:0]   HCNT_LAST = HW'(LONG_PRESS_MS - 1);
    localparam bit              LONG_EN   = (LONG_PRESS_MS != 0);

    btn_state_t    state_q;
    logic [7:0]    dcnt_q;
    logic [HW-1:0] hcnt_q;
    logic          level_q, press_q, release_q, long_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RELEASED;
            dcnt_q    <= '0;
            hcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;

            // Hold time keeps accumulating through a pending release so a glitch does not restart it.
            if (LONG_EN && tick_i && (state_q == PRESSED || state_q == RELEASE_PEND)
                && (hcnt_q != HCNT_MAX)) begin
                hcnt_q <= hcnt_q + 1'b1;
                if (hcnt_q == HCNT_LAST) begin
                    long_q <= 1'b1;
                end
            end

            case (state_q)
                RELEASED: begin
                    if (act_i) begin
                        state_q <= PRESS_PEND;
                        dcnt_q  <= '0;
                    end
                end
                PRESS_PEND: begin
                    if (!act_i) begin
                        state_q <= RELEASED;
                        dcnt_q  <= '0;
                    end else if (tick_i) begin
                        if (dcnt_q == DCNT_LAST) begin
                            state_q <= PRESSED;
                            dcnt_q  <= '0;
                            hcnt_q  <= '0;
                            press_q <= 1'b1;
                            level_q <= 1'b1;
                        end else begin
                            dcnt_q <= dcnt_q + 1'b1;
                        end
                    end
                end
                PRESSED: begin
                    if (!act_i) begin
                        state_q <= RELEASE_PEND;
                        dcnt_q  <= '0;
                    end
                end
                RELEASE_PEND: begin
                    if (act_i) begin
                        state_q <= PRESSED;
                    end else if (tick_i) begin
                        if (dcnt_q == DCNT_LAST) begin
                            // A release wins over a coincident long-press tick.
                            state_q   <= RELEASED;
                            dcnt_q    <= '0;
                            release_q <= 1'b1;
                            level_q   <= 1'b0;
                            long_q    <= 1'b0;
                        end else begin
                            dcnt_q <= dcnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= RELEASED;
            endcase
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: rtl/btn_debounce_ctrl.sv
// Board input front end: synchronises raw button pins, derives a 1 ms tick and
// debounces every channel into a clean level plus press/release/long pulses.
module btn_debounce_ctrl
    import btn_pkg::*;
#(
    parameter int   CLK_IN_MHZ    = 12,
    parameter int   TICK_CYCLES   = CLK_IN_MHZ * 1000,
    parameter int   NUM_INPUTS    = 8,
    parameter int   DEBOUNCE_MS   = 10,
    parameter int   LONG_PRESS_MS = 1000,
    parameter logic IN_POLARITY   = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_INPUTS-1:0] btn_raw_i,
    output logic [NUM_INPUTS-1:0] btn_level_o,
    output logic [NUM_INPUTS-1:0] press_o,
    output logic [NUM_INPUTS-1:0] release_o,
    output logic [NUM_INPUTS-1:0] long_o,
    output logic                  any_event_o
);

    localparam int                    PW       = clog2_safe(TICK_CYCLES);
    localparam logic [PW-1:0]         PRE_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [NUM_INPUTS-1:0] IDLE     = {NUM_INPUTS{~IN_POLARITY}};

    logic [NUM_INPUTS-1:0] sync1_q, sync2_q;
    logic [NUM_INPUTS-1:0] act;
    logic [PW-1:0]         pre_q;
    logic                  tick;

    // Synchronisers come out of reset at the idle level so reset never looks like a press.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= IDLE;
            sync2_q <= IDLE;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign act = sync2_q ^ IDLE;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_q <= '0;
        end else if (pre_q == PRE_LAST) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    assign tick = (pre_q == PRE_LAST);

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_chan
        btn_debounce_chan #(
            .DEBOUNCE_MS   (DEBOUNCE_MS),
            .LONG_PRESS_MS (LONG_PRESS_MS)
        ) u_chan (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .tick_i    (tick),
            .act_i     (act[g]),
            .level_o   (btn_level_o[g]),
            .press_o   (press_o[g]),
            .release_o (release_o[g]),
            .long_o    (long_o[g])
        );
    end

    assign any_event_o = |(press_o | release_o | long_o);

endmodule

// File: tb/tb_btn_debounce_ctrl.sv
// Directed bench for btn_debounce_ctrl: stimulus pushes expected events with
// cycle windows into a scoreboard that a negedge monitor drains.
module tb_btn_debounce_ctrl;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_i;
    logic [N-1:0] raw, level, press, rel, lng;
    logic         any;
    logic [N-1:0] raw2, level2, press2, rel2, lng2;
    logic         any2;

    btn_debounce_ctrl #(
        .TICK_CYCLES(10), .NUM_INPUTS(N), .DEBOUNCE_MS(4),
        .LONG_PRESS_MS(20), .IN_POLARITY(1'b0)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .btn_raw_i(raw), .btn_level_o(level),
        .press_o(press), .release_o(rel), .long_o(lng), .any_event_o(any)
    );

    btn_debounce_ctrl #(
        .TICK_CYCLES(10), .NUM_INPUTS(N), .DEBOUNCE_MS(4),
        .LONG_PRESS_MS(0), .IN_POLARITY(1'b1)
    ) dut2 (
        .clk_i(clk), .rst_i(rst_i), .btn_raw_i(raw2), .btn_level_o(level2),
        .press_o(press2), .release_o(rel2), .long_o(lng2), .any_event_o(any2)
    );

    typedef struct {
        string        name;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] lng;
        int           lo;
        int           hi;
    } exp_t;

    exp_t sb[$];
    exp_t got_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc;
    int   n_press2 = 0, n_rel2 = 0, n_long2 = 0;
    int   p, q;

    always @(posedge clk) begin
        if (rst_i) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (any || (|press) || (|rel) || (|lng)) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event cyc=%0d actual press=%b release=%b long=%b any=%b required no event",
                         cyc, press, rel, lng, any);
            end else begin
                got_e = sb.pop_front();
                if (press !== got_e.press || rel !== got_e.rel || lng !== got_e.lng ||
                    any !== 1'b1 || cyc < got_e.lo || cyc > got_e.hi) begin
                    failures++;
                    $display("FAIL %s actual press=%b release=%b long=%b any=%b cyc=%0d required press=%b release=%b long=%b any=1 cyc=%0d..%0d",
                             got_e.name, press, rel, lng, any, cyc,
                             got_e.press, got_e.rel, got_e.lng, got_e.lo, got_e.hi);
                end
            end
        end
        n_press2 += $countones(press2);
        n_rel2   += $countones(rel2);
        n_long2  += $countones(lng2);
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic push(input string name, input logic [N-1:0] pr, input logic [N-1:0] rl,
                        input logic [N-1:0] lg, input int lo, input int hi);
        exp_t e;
        e.name  = name;
        e.press = pr;
        e.rel   = rl;
        e.lng   = lg;
        e.lo    = lo;
        e.hi    = hi;
        sb.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Align stimulus to a fixed prescaler phase so latencies sit mid-window.
    task automatic to_phase();
        @(posedge clk);
        #1;
        while (cyc % 10 != 5) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_i = 1'b1;
        raw   = '1;
        raw2  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_level", 32'(level), 32'h0);
        check("reset_pulses", 32'({press, rel, lng, any}), 32'h0);
        check("reset_dut2", 32'({level2, press2, rel2, lng2, any2}), 32'h0);
        @(posedge clk);
        #1 rst_i = 1'b0;

        // Clean press and release on channel 0
        to_phase(); p = cyc; raw[0] = 1'b0;
        push("t1_press", 4'b0001, 4'b0000, 4'b0000, p + 32, p + 42);
        cycles(100);
        @(negedge clk); check("t1_level_pressed", 32'(level), 32'h1);
        to_phase(); q = cyc; raw[0] = 1'b1;
        push("t1_release", 4'b0000, 4'b0001, 4'b0000, q + 32, q + 42);
        cycles(60);
        @(negedge clk); check("t1_level_released", 32'(level), 32'h0);

        // Bounce on channel 1 never qualifies
        for (int k = 0; k < 29; k++) begin
            raw[1] = ~raw[1];
            cycles(7);
        end
        raw[1] = 1'b1;
        cycles(60);
        @(negedge clk); check("t2_level_bounce", 32'(level), 32'h0);

        // Release glitch on channel 2, then long press, then clean release
        to_phase(); p = cyc; raw[2] = 1'b0;
        push("t3_press", 4'b0100, 4'b0000, 4'b0000, p + 32, p + 42);
        cycles(60);
        @(negedge clk); check("t3_level_pressed", 32'(level), 32'h4);
        raw[2] = 1'b1;
        cycles(15);
        raw[2] = 1'b0;
        push("t3_long", 4'b0000, 4'b0000, 4'b0100, p + 232, p + 242);
        cycles(200);
        @(negedge clk); check("t3_level_after_glitch", 32'(level), 32'h4);
        to_phase(); q = cyc; raw[2] = 1'b1;
        push("t3_release", 4'b0000, 4'b0100, 4'b0000, q + 32, q + 42);
        cycles(60);
        @(negedge clk); check("t3_level_released", 32'(level), 32'h0);

        // Simultaneous press and release on channels 0 and 3
        to_phase(); p = cyc; raw[0] = 1'b0; raw[3] = 1'b0;
        push("t4_press", 4'b1001, 4'b0000, 4'b0000, p + 32, p + 42);
        cycles(60);
        @(negedge clk); check("t4_level_pressed", 32'(level), 32'h9);
        to_phase(); q = cyc; raw[0] = 1'b1; raw[3] = 1'b1;
        push("t4_release", 4'b0000, 4'b1001, 4'b0000, q + 32, q + 42);
        cycles(60);
        @(negedge clk); check("t4_level_released", 32'(level), 32'h0);

        // Reset while a press is pending on channel 0
        @(posedge clk); #1;
        raw[0] = 1'b0;
        cycles(20);
        rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk); check("t5_reset_cycle", 32'({level, press, rel, lng, any}), 32'h0);
        push("t5_press", 4'b0001, 4'b0000, 4'b0000, 32, 42);
        @(negedge clk); check("t5_after_reset", 32'({level, press, rel, lng, any}), 32'h0);
        cycles(60);
        @(negedge clk); check("t5_level_pressed", 32'(level), 32'h1);
        to_phase(); q = cyc; raw[0] = 1'b1;
        push("t5_release", 4'b0000, 4'b0001, 4'b0000, q + 32, q + 42);
        cycles(60);
        @(negedge clk); check("t5_level_released", 32'(level), 32'h0);

        // Active-high pin with long press disabled
        @(posedge clk); #1;
        raw2[0] = 1'b1;
        cycles(400);
        @(negedge clk);
        check("t6_level", 32'(level2), 32'h1);
        check("t6_press_count", 32'(n_press2), 32'd1);
        check("t6_long_count", 32'(n_long2), 32'd0);
        check("t6_release_count", 32'(n_rel2), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_debounce_ctrl.md
Name: btn_debounce_ctrl

Overview:
- Board input front end: samples raw push-button/DIP-switch pins and debounces each channel against a shared 1 ms tick.
- Emits a clean level plus single-cycle press, release and long-press event pulses per channel.
- Sits beside the LED/segment drivers in the board check top. It supplies user stimulus that those drivers, or future board-check logic, act on.

Parameters:
- CLK_IN_MHZ, 12: input clock frequency in MHz.
- TICK_CYCLES, CLK_IN_MHZ*1000: clock cycles per 1 ms tick. Override with a small value for simulation.
- NUM_INPUTS, 8: number of independent input channels.
- DEBOUNCE_MS, 10: number of ticks an input must hold stable before a level change is accepted. Must be ≥1.
- LONG_PRESS_MS, 1000: ticks held pressed before long_o fires. 0 disables long-press detection.
- IN_POLARITY, 1'b0: pin level meaning "pressed" (0 = active-low buttons).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, synchronous to clk_i, active-high.
- btn_raw_i  in  NUM_INPUTS  asynchronous raw pin levels.
- btn_level_o  out  NUM_INPUTS  debounced state, 1 = pressed (polarity-normalised).
- press_o  out  NUM_INPUTS  one-cycle pulse when a press is accepted.
- release_o  out  NUM_INPUTS  one-cycle pulse when a release is accepted.
- long_o  out  NUM_INPUTS  one-cycle pulse on reaching LONG_PRESS_MS while held.
- any_event_o  out  1  OR of press_o | release_o | long_o, same cycle.

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - All outputs 0; every channel FSM in RELEASED; tick prescaler 0; all counters 0.
  - Synchroniser flops load the inactive level (~IN_POLARITY), so no spurious press follows reset.
- Synchroniser:
  - 2-flop per channel, then XOR with ~IN_POLARITY to give act[i] (1 = pressed).
  - Pin-to-act latency is 2 cycles.
- Tick prescaler:
  - Counts 0..TICK_CYCLES-1 and wraps.
  - tick is a one-cycle pulse when the count equals TICK_CYCLES-1.
  - Free-running and shared by all channels.
- Per-channel FSM (RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND) with an 8-bit debounce counter dcnt:
  - RELEASED: act=1 → PRESS_PEND with dcnt=0.
  - PRESS_PEND:
    - act=0 on any cycle → RELEASED with dcnt=0; no pulse.
    - Otherwise dcnt increments on each tick.
    - On the tick where dcnt reaches DEBOUNCE_MS-1 → PRESSED; press_o=1 for that one cycle; btn_level_o=1 from the next cycle.
  - PRESSED: act=0 → RELEASE_PEND with dcnt=0.
  - RELEASE_PEND:
    - act=1 on any cycle → back to PRESSED; no pulse; hold counter preserved.
    - After DEBOUNCE_MS stable ticks → RELEASED; release_o=1 for one cycle; btn_level_o=0 from the next cycle.
- Accepted debounce window: between (DEBOUNCE_MS-1)*TICK_CYCLES and DEBOUNCE_MS*TICK_CYCLES cycles, because the first tick is partial.
- Long press:
  - Hold counter hcnt (clog2(LONG_PRESS_MS+1) bits) clears on entry to PRESSED from PRESS_PEND.
  - hcnt increments per tick in PRESSED and RELEASE_PEND, saturating at LONG_PRESS_MS.
  - On the tick where hcnt becomes LONG_PRESS_MS, long_o pulses once.
  - No repeat until the next accepted press. Never fires when LONG_PRESS_MS=0.
- Simultaneous events:
  - Channels are fully independent; multiple bits may pulse in the same cycle.
  - press_o and release_o are never both 1 on one channel.
  - long_o may coincide only with no other event on that channel.
- Reset mid-operation: pending presses and releases are discarded; no pulses in the reset cycle or the cycle after.
- Outputs are all registered.

Decomposition:
- Package btn_pkg:
  - enum btn_state_t {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND}.
  - Function clog2_safe for counter widths.
- Sub-module btn_debounce_chan: one channel's FSM, dcnt and hcnt.
  - Inputs: clk_i, rst_i, tick, act.
  - Outputs: level, press, release, long.
- The top instantiates the synchroniser, the prescaler and NUM_INPUTS channel instances in a generate loop.

Test Plan:
Common parameters for every scenario: TICK_CYCLES=10, DEBOUNCE_MS=4, LONG_PRESS_MS=20, NUM_INPUTS=4, IN_POLARITY=0.
1. Clean press: hold btn_raw_i[0]=0 for 100 cycles → exactly one press_o[0] pulse, 32–42 cycles after the pin edge; btn_level_o[0]=1 thereafter; no other bits active.
2. Bounce rejection: toggle btn_raw_i[1] every 7 cycles for 200 cycles, then hold high → press_o, release_o and long_o all stay 0; btn_level_o[1] stays 0.
3. Release glitch: from the pressed state, pulse the pin high for 15 cycles and then low → no release_o; hcnt continues; long_o[2] fires once about 200 cycles after the accepted press; a later clean release gives one release_o.
4. Multi-channel: press channels 0 and 3 on the same cycle → press_o=4'b1001 in a single cycle; any_event_o=1 in that cycle only.
5. Reset mid-pending: start a press on channel 0, assert rst_i at 20 cycles for 1 cycle, keep the pin low → all outputs 0 through reset; debounce restarts; press_o[0] occurs 32–42 cycles after rst_i deasserts.
6. Polarity and disable: IN_POLARITY=1, LONG_PRESS_MS=0, hold pin high for 400 cycles → press_o fires once; long_o never fires.
